// File: rtl/bus_trace_uart.sv
// RC2014 bus write tracer: captures matching memory writes into a FIFO and emits each one as an
// ASCII hex line over a ready/valid character port. Define BUS_TRACE_READS_EN to trace reads too.
module bus_trace_uart #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DEPTH      = 8,
    parameter logic [ADDR_W-1:0] MATCH_ADDR = 16'hFFFF,
    parameter logic [ADDR_W-1:0] MATCH_MASK = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus_a,
    input  logic [7:0]        bus_d,
    input  logic              bus_mreq_n,
    input  logic              bus_wr_n,
    input  logic              bus_rd_n,
    input  logic              tx_ready,
    output logic              tx_req,
    output logic [7:0]        tx_data,
    output logic              overflow,
    output logic              capture_pulse
);

    localparam int unsigned NH = ADDR_W / 4;
`ifdef BUS_TRACE_READS_EN
    localparam int unsigned ENTRY_W = ADDR_W + 9;
    localparam int unsigned PFX     = 2;
`else
    localparam int unsigned ENTRY_W = ADDR_W + 8;
    localparam int unsigned PFX     = 0;
`endif
    localparam int unsigned LEN   = PFX + NH + 5;
    localparam int unsigned IDX_W = $clog2(LEN);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e             state_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] line_q;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] cap_entry;
    logic [IDX_W-1:0]   idx_q;
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q, occ_q, occ_d;
    logic               wr_prev_q, wr_act, wr_evt, addr_hit;
    logic               cap_evt, full, push, line_done;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] line_char(input logic [ENTRY_W-1:0] e,
                                             input logic [IDX_W-1:0] idx);
        int unsigned       i;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        a = e[ADDR_W+7:8];
        d = e[7:0];
        i = 32'(idx);
`ifdef BUS_TRACE_READS_EN
        if (i == 0) return e[ENTRY_W-1] ? 8'h52 : 8'h57;
        if (i == 1) return 8'h20;
        i = i - 2;
`endif
        if (i < NH) return hex_char(4'(a >> (4 * (NH - 1 - i))));
        if (i == NH) return 8'h20;
        if (i == NH + 1) return hex_char(d[7:4]);
        if (i == NH + 2) return hex_char(d[3:0]);
        if (i == NH + 3) return 8'h0D;
        return 8'h0A;
    endfunction

    assign addr_hit = (bus_a & MATCH_MASK) == (MATCH_ADDR & MATCH_MASK);
    assign wr_act   = !bus_mreq_n && !bus_wr_n;
    assign wr_evt   = wr_act && !wr_prev_q && addr_hit;

`ifdef BUS_TRACE_READS_EN
    logic rd_prev_q, rd_act, rd_evt;
    assign rd_act    = !bus_mreq_n && !bus_rd_n;
    assign rd_evt    = rd_act && !rd_prev_q && addr_hit;
    // A coincident write wins; type bit is 1 for reads.
    assign cap_evt   = wr_evt || rd_evt;
    assign cap_entry = {!wr_evt, bus_a, bus_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_prev_q <= 1'b0;
        else       rd_prev_q <= rd_act;
    end
`else
    logic unused_rd;
    assign unused_rd = bus_rd_n;
    assign cap_evt   = wr_evt;
    assign cap_entry = {bus_a, bus_d};
`endif

    // Occupancy counts the line being sent, so a slot frees only once its line is fully accepted.
    assign full      = occ_q == OCC_FULL;
    assign push      = cap_evt && !full;
    assign line_done = (state_q == StSend) && tx_ready && (idx_q == LAST_IDX);
    assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        occ_d = occ_q;
        if (push && !line_done)      occ_d = occ_q + PTR_ONE;
        else if (!push && line_done) occ_d = occ_q - PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= cap_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            overflow      <= 1'b0;
            capture_pulse <= 1'b0;
            state_q       <= StIdle;
            idx_q         <= '0;
            line_q        <= '0;
            tx_req        <= 1'b0;
            tx_data       <= 8'h00;
        end else begin
            wr_prev_q     <= wr_act;
            occ_q         <= occ_d;
            capture_pulse <= push;
            if (cap_evt && full) overflow <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;

            case (state_q)
                StIdle: begin
                    if (wr_ptr_q != rd_ptr_q) state_q <= StLoad;
                end
                StLoad: begin
                    line_q   <= head;
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    idx_q    <= '0;
                    tx_data  <= line_char(head, '0);
                    tx_req   <= 1'b1;
                    state_q  <= StSend;
                end
                StSend: begin
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            tx_req  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + IDX_ONE;
                            tx_data <= line_char(line_q, idx_q + IDX_ONE);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_trace_uart.sv
// Self-checking bench for bus_trace_uart: directed cases plus random bus traffic against a
// string-level scoreboard of expected trace lines.
module tb_bus_trace_uart;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam logic [ADDR_W-1:0] MADDR = 16'hFFFF;
    localparam logic [ADDR_W-1:0] MMASK = 16'hFFFF;
`ifdef BUS_TRACE_READS_EN
    localparam int LINE_LEN = 11;
`else
    localparam int LINE_LEN = 9;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] bus_a = '0;
    logic [7:0]        bus_d = '0;
    logic              bus_mreq_n = 1'b1;
    logic              bus_wr_n = 1'b1;
    logic              bus_rd_n = 1'b1;
    logic              tx_ready = 1'b0;
    logic              tx_req;
    logic [7:0]        tx_data;
    logic              overflow;
    logic              capture_pulse;

    bus_trace_uart #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .MATCH_ADDR (MADDR),
        .MATCH_MASK (MMASK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_a         (bus_a),
        .bus_d         (bus_d),
        .bus_mreq_n    (bus_mreq_n),
        .bus_wr_n      (bus_wr_n),
        .bus_rd_n      (bus_rd_n),
        .tx_ready      (tx_ready),
        .tx_req        (tx_req),
        .tx_data       (tx_data),
        .overflow      (overflow),
        .capture_pulse (capture_pulse)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    int         occ = 0;
    int         line_pos = 0;
    int         lowrun = 0;
    int         n_pulse = 0;
    int         n_lines = 0;
    logic       exp_pulse = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_gap = 1'b0;
    logic       stall_pending = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       prev_wr = 1'b0;
    logic       prev_rd = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected line built from formatted strings rather than per-character logic.
    task automatic model_push(input logic is_rd, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        string s;
        string pfx;
        pfx = is_rd ? "R " : "W ";
        s = $sformatf("%h %h", a, d);
        s = s.toupper();
`ifdef BUS_TRACE_READS_EN
        s = {pfx, s};
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called at a negedge: check outputs, drive inputs, predict the next posedge.
    task automatic step(input logic mreq_n, input logic wr_n, input logic rd_n,
                        input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic rdy);
        logic wr_a, rd_a, hit, wr_e, rd_e, rel;
        check("pulse", capture_pulse, exp_pulse);
        check("overflow", overflow, exp_ovf);
        if (capture_pulse) n_pulse++;
        if (stall_pending) begin
            check("stall_req", tx_req, 1'b1);
            check("stall_data", tx_data, stall_data);
        end
        if (exp_gap) check("line_gap", tx_req, 1'b0);
        if (tx_req) lowrun = 0;
        else if (exp_q.size() > 0) begin
            lowrun++;
            check("latency", 32'(lowrun <= 3), 32'd1);
        end

        bus_mreq_n = mreq_n;
        bus_wr_n   = wr_n;
        bus_rd_n   = rd_n;
        bus_a      = a;
        bus_d      = d;
        tx_ready   = rdy;

        exp_pulse = 1'b0;
        exp_gap   = 1'b0;
        rel       = 1'b0;
        if (tx_req && rdy) begin
            if (exp_q.size() == 0) check("spurious", tx_req, 1'b0);
            else begin
                check("char", tx_data, exp_q.pop_front());
                if (line_pos == LINE_LEN - 1) begin
                    line_pos = 0;
                    rel      = 1'b1;
                    exp_gap  = 1'b1;
                    n_lines++;
                end else line_pos++;
            end
        end
        stall_pending = tx_req && !rdy;
        stall_data    = tx_data;

        hit  = (a & MMASK) == (MADDR & MMASK);
        wr_a = !mreq_n && !wr_n;
        rd_a = !mreq_n && !rd_n;
        wr_e = wr_a && !prev_wr && hit;
`ifdef BUS_TRACE_READS_EN
        rd_e = rd_a && !prev_rd && hit;
`else
        rd_e = 1'b0;
`endif
        prev_wr = wr_a;
        prev_rd = rd_a;
        if (wr_e || rd_e) begin
            if (occ < int'(DEPTH)) begin
                occ++;
                exp_pulse = 1'b1;
                model_push(!wr_e, a, d);
            end else exp_ovf = 1'b1;
        end
        if (rel) occ--;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b1, 1'b1, '0, '0, rdy);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic rdy);
        step(1'b0, 1'b0, 1'b1, a, d, rdy);
        step(1'b1, 1'b1, 1'b1, a, d, rdy);
    endtask

    task automatic drain;
        for (int i = 0; i < 600 && (exp_q.size() > 0 || tx_req); i++) idle(1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        bus_mreq_n = 1'b1;
        bus_wr_n   = 1'b1;
        bus_rd_n   = 1'b1;
        #1;
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_pulse", capture_pulse, 1'b0);
        exp_q.delete();
        occ = 0; line_pos = 0; lowrun = 0;
        exp_pulse = 1'b0; exp_ovf = 1'b0; exp_gap = 1'b0; stall_pending = 1'b0;
        prev_wr = 1'b0; prev_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int p0, l0;
        #1;
        do_reset();

        // Single matching write, ready held high.
        p0 = n_pulse;
        wr(16'hFFFF, 8'h5A, 1'b1);
        drain();
        check("pulse_once", n_pulse - p0, 1);

        // Non-matching address.
        p0 = n_pulse;
        wr(16'h1234, 8'h77, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("no_req", tx_req, 1'b0);
            idle(1'b1);
        end
        check("no_pulse", n_pulse - p0, 0);

        // Ready toggling every cycle during a line.
        wr(16'hFFFF, 8'hA7, 1'b0);
        for (int i = 0; i < 30; i++) idle(1'(i % 2));
        drain();

        // Overflow: ten writes into a stalled formatter.
        p0 = n_pulse;
        l0 = n_lines;
        for (int i = 0; i < 10; i++) wr(16'hFFFF, 8'(i), 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_pulses", n_pulse - p0, 8);
        drain();
        check("ovf_lines", n_lines - l0, 8);

        // Reset while the fourth character is presented.
        wr(16'hFFFF, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        for (int i = 0; i < 20 && line_pos != 3; i++) idle(1'b1);
        check("reach_4th", 32'(line_pos), 32'd3);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check("post_rst_idle", tx_req, 1'b0);
            idle(1'b1);
        end
        wr(16'hFFFF, 8'hE1, 1'b1);
        drain();

`ifdef BUS_TRACE_READS_EN
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'hC3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hC3, 1'b1);
        drain();
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 9) < 6) ? 16'hFFFF : ADDR_W'($urandom());
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), a, 8'($urandom()),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
